// File: rtl/or_reduce_arbiter_if.sv
// Request/response bundle for or_reduce_arbiter: per-requester valid/data/ready plus a
// single result channel. The slave modport is the arbiter's view.
interface or_reduce_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ*DATA_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic                      resp_valid_out;
    logic [IdW-1:0]            resp_id_out;
    logic                      resp_any_out;
    logic                      resp_zero_out;
    logic                      resp_ready_in;

    modport slave (
        input  req_valid_in,
        input  req_data_in,
        input  resp_ready_in,
        output req_ready_out,
        output resp_valid_out,
        output resp_id_out,
        output resp_any_out,
        output resp_zero_out
    );

    modport master (
        output req_valid_in,
        output req_data_in,
        output resp_ready_in,
        input  req_ready_out,
        input  resp_valid_out,
        input  resp_id_out,
        input  resp_any_out,
        input  resp_zero_out
    );
endinterface

// File: rtl/or_reduce_arbiter.sv
// Round-robin arbiter sharing one 8-input OR reducer among NUM_REQ requesters; each accepted
// word is reduced one byte per cycle, LSB byte first, and returned as any/zero flags.
module or_reduce_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input logic               clk_in,
    input logic               rst_n_in,
    or_reduce_arbiter_if.slave bus
);
    localparam int unsigned BEATS = DATA_W / 8;
    localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               acc_q, acc_d;
    logic [IdW-1:0]     rid_q, rid_d;
    logic               any_q, any_d;
    logic               zero_q, zero_d;

    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grant_id;
    logic               found;
    logic [31:0]        idx;
    logic [DATA_W-1:0]  word_sel;
    logic [7:0]         byte_sel;
    logic               byte_or;
    logic               acc_next;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last_q) + 32'd1 + i) % NUM_REQ;
            if (!found && bus.req_valid_in[idx[IdW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IdW-1:0]]   = 1'b1;
                grant_id              = idx[IdW-1:0];
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) word_sel = bus.req_data_in[i*DATA_W +: DATA_W];
        end
    end

    // The single shared OR8: its input is the current byte of the latched word.
    always_comb begin
        byte_sel = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BeatW'(b)) byte_sel = word_q[b*8 +: 8];
        end
    end

    assign byte_or  = |byte_sel;
    assign acc_next = acc_q | byte_or;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        rid_d   = rid_q;
        any_d   = any_q;
        zero_d  = zero_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    word_d  = word_sel;
                    last_d  = grant_id;
                    beat_d  = '0;
                    acc_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d  = acc_next;
                beat_d = beat_q + BeatW'(1);
                if ((beat_q == BeatW'(BEATS - 1)) || (EARLY_EXIT && byte_or)) begin
                    rid_d   = last_q;
                    any_d   = acc_next;
                    zero_d  = ~acc_next;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // last_q resets to NUM_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            word_q  <= '0;
            last_q  <= IdW'(NUM_REQ - 1);
            beat_q  <= '0;
            acc_q   <= 1'b0;
            rid_q   <= '0;
            any_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            rid_q   <= rid_d;
            any_q   <= any_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.req_ready_out  = (state_q == StIdle && rst_n_in) ? grant : '0;
    assign bus.resp_valid_out = (state_q == StResp);
    assign bus.resp_id_out    = rid_q;
    assign bus.resp_any_out   = any_q;
    assign bus.resp_zero_out  = zero_q;
endmodule

// File: doc/or_reduce_arbiter.md
Name: or_reduce_arbiter

Overview:
- Shares one or_8x1 reduction unit among NUM_REQ requesters.
- Each requester submits a DATA_W-bit word. The block returns its OR-reduction (any-bit-set) and zero flag, the Hack ALU zr-style test.
- Words are processed one byte per cycle through the single shared OR8 instance.
- Sits beside the hack_n2t ALU/CPU as the time-multiplexed zero-detect resource.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 16, word width; must be a multiple of 8. BEATS = DATA_W/8.
- EARLY_EXIT, 0, when 1, processing stops at the first byte whose OR is 1.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- req_valid_in  input  NUM_REQ  per-requester request valid
- req_data_in  input  NUM_REQ*DATA_W  requester i's word in slice [i*DATA_W +: DATA_W]
- req_ready_out  output  NUM_REQ  one-hot accept strobe
- resp_valid_out  output  1  result valid
- resp_id_out  output  max(1,$clog2(NUM_REQ))  index of the served requester
- resp_any_out  output  1  OR of all DATA_W bits
- resp_zero_out  output  1  ~resp_any_out
- resp_ready_in  input  1  consumer accepts the result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n_in). While low:
  - state=IDLE, all outputs 0, resp_zero_out=0, accumulator=0, beat counter=0.
  - RR pointer set so requester 0 has highest priority.
- Reset asserted mid-operation aborts the request. No response is produced and the requester is not re-served automatically.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Round-robin arbitration over req_valid_in, starting at index (last_grant+1) mod NUM_REQ.
  - req_ready_out is combinational: one-hot winner bit, asserted only in IDLE when any valid.
  - On the accept edge: latch the winner's word and id, clear the accumulator, beat=0, last_grant=winner, go to BUSY.
  - No valid: stay in IDLE, req_ready_out=0.
- BUSY:
  - The or_8x1 input is byte[beat] of the latched word, LSB byte first.
  - Each cycle: acc <= acc | y; beat <= beat+1.
  - Exit to RESP after the byte beat=BEATS-1 is accumulated.
  - If EARLY_EXIT=1 and y=1, exit to RESP immediately; remaining bytes are skipped.
  - req_ready_out=0 throughout.
- RESP:
  - resp_valid_out=1; resp_id_out, resp_any_out=acc and resp_zero_out=~acc are held stable until resp_ready_in=1.
  - On the handshake edge go to IDLE; resp_valid_out drops next cycle.
  - resp_ready_in is ignored outside RESP.
- Latency, accept edge to resp_valid_out high:
  - EARLY_EXIT=0: BEATS cycles.
  - EARLY_EXIT=1: k cycles, where k is the 1-based index of the first nonzero byte; BEATS if the word is zero.
- Minimum spacing between accepts: BEATS+2 cycles. A new grant happens in the IDLE cycle after the handshake, never in the same cycle.
- Requester rules:
  - Must hold valid and data stable until its req_ready_out pulse.
  - Dropping valid before grant is legal; that requester is simply skipped.
- Data changes after accept do not affect the result, because the word is latched.
- The accepted requester may re-assert immediately. It is queued behind the other valid requesters per RR order.
- In IDLE, resp_id_out, resp_any_out and resp_zero_out hold their last values; they are qualified only by resp_valid_out.
- Invariants:
  - req_ready_out is at most one-hot.
  - Never req_ready_out≠0 and resp_valid_out=1 in the same cycle.

Test Plan:
- Single request, zero word: NUM_REQ=4, DATA_W=16, req_valid_in=0001, data 0x0000, accepted at edge T. Required: resp_valid_out high after edge T+2, resp_id_out=0, resp_any_out=0, resp_zero_out=1.
- High-byte-only nonzero word: requester 2 sends 0x0100. Required: resp_any_out=1, resp_zero_out=0, id=2. With EARLY_EXIT=1, still 2-cycle latency. Then 0x0001 with EARLY_EXIT=1 gives 1-cycle latency.
- Round-robin fairness: all four valids held high with distinct words and resp_ready_in tied 1. Required: grant order 0,1,2,3,0, accepts exactly 4 cycles apart (BEATS+2), correct id/any per response.
- Back-pressure: resp_ready_in=0 for 5 cycles in RESP while other valids are pending. Required: outputs stable, no req_ready_out pulses; next grant in the cycle after resp_ready_in rises.
- Async reset mid-BUSY: rst_n_in low between clock edges during beat 0. Required: outputs 0 immediately; no response after release. The first grant after reset goes to requester 0 if valid.
- Withdrawn request: requester 1 drops valid while requester 0 is being served. Required: the next grant skips 1 and goes to the next valid index; req_ready_out is never asserted for 1.
